// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC controller.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JALR = 2'd2,
        SEL_TRAP = 2'd3
    } next_sel_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        UPDATE = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] PC_RESET = 32'd0;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection; MISALIGN_TRAP_EN redirects misaligned
// branch/jalr targets to trap_vec, otherwise the low two bits are cleared.
module pc_next_mux
    import pc_pkg::*;
(
    input  next_sel_t   sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] trap_vec_i,
    output logic [31:0] pc_next_o,
    output logic        misaligned_o
);

    logic [31:0] cand;

    always_comb begin
        cand = pc_i + PC_INCR;
        case (sel_i)
            SEL_SEQ:  cand = pc_i + PC_INCR;
            SEL_BR:   cand = branch_tgt_i;
            SEL_JALR: cand = jalr_tgt_i & ~32'h1;
            SEL_TRAP: cand = trap_vec_i;
            default:  cand = pc_i + PC_INCR;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        pc_next_o    = cand;
        misaligned_o = 1'b0;
        if ((sel_i == SEL_BR || sel_i == SEL_JALR) && cand[1:0] != 2'b00) begin
            pc_next_o    = trap_vec_i;
            misaligned_o = 1'b1;
        end
    end
`else
    assign pc_next_o    = cand & ~32'h3;
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/pc_next_ctrl.sv
// FETCH/EXEC/UPDATE sequencer producing the PC load strobe and fetch requests.
// Optional MISALIGN_TRAP_EN (see pc_next_mux) traps misaligned control-flow targets.
module pc_next_ctrl
    import pc_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_count,
    output logic        pc_ld,
    output logic [31:0] pc_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [1:0]  next_sel,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] trap_vec,
    output logic        misaligned,
    output logic [31:0] instret
);

    pc_state_t   state_q, state_d;
    logic        run_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    next_sel_t   sel_q;
    logic [31:0] br_q, jalr_q, trap_q;
    logic        fetch_act;
    logic [31:0] mux_pc;
    logic        mux_mis;

    // run_q keeps the first post-reset cycle quiet so imem_req rises one cycle after release
    assign fetch_act = run_q && (state_q == FETCH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (fetch_act && imem_ack) state_d = EXEC;
            EXEC:    if (exec_done)             state_d = UPDATE;
            UPDATE:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= FETCH;
            run_q     <= 1'b0;
            instr_q   <= '0;
            instret_q <= '0;
            sel_q     <= SEL_SEQ;
            br_q      <= PC_RESET;
            jalr_q    <= PC_RESET;
            trap_q    <= PC_RESET;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (fetch_act && imem_ack) begin
                instr_q <= imem_rdata;
            end
            // Count on entry to UPDATE so instret already reflects the retiring instruction during pc_ld
            if (state_q == EXEC && exec_done) begin
                sel_q     <= next_sel_t'(next_sel);
                br_q      <= branch_tgt;
                jalr_q    <= jalr_tgt;
                trap_q    <= trap_vec;
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    pc_next_mux u_mux (
        .sel_i        (sel_q),
        .pc_i         (pc_count),
        .branch_tgt_i (br_q),
        .jalr_tgt_i   (jalr_q),
        .trap_vec_i   (trap_q),
        .pc_next_o    (mux_pc),
        .misaligned_o (mux_mis)
    );

    assign imem_req    = fetch_act;
    assign imem_addr   = fetch_act ? pc_count : PC_RESET;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign pc_ld       = (state_q == UPDATE);
    assign pc_data     = pc_ld ? mux_pc : PC_RESET;
    assign misaligned  = pc_ld && mux_mis;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl; expectations follow MISALIGN_TRAP_EN when defined.
module tb_pc_next_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_count;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  next_sel;
    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] trap_vec;
    logic        misaligned;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_next_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_count    (pc_count),
        .pc_ld       (pc_ld),
        .pc_data     (pc_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .next_sel    (next_sel),
        .branch_tgt  (branch_tgt),
        .jalr_tgt    (jalr_tgt),
        .trap_vec    (trap_vec),
        .misaligned  (misaligned),
        .instret     (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pc_ld"},       32'(pc_ld),       32'd0);
        chk({tag, ".pc_data"},     pc_data,          32'd0);
        chk({tag, ".imem_req"},    32'(imem_req),    32'd0);
        chk({tag, ".instr"},       instr,            32'd0);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".misaligned"},  32'(misaligned),  32'd0);
        chk({tag, ".instret"},     instret,          32'd0);
    endtask

    // Called in a FETCH cycle; runs one instruction at the 3-cycle minimum period.
    task automatic one_instr(input string tag, input logic [31:0] pc, input logic [1:0] sel,
                             input logic [31:0] tgt, input logic [31:0] exp_pc,
                             input logic exp_mis, input logic [31:0] exp_ret);
        logic [31:0] word;
        word       = pc ^ 32'hA5A5_0013;
        pc_count   = pc;
        imem_ack   = 1'b1;
        imem_rdata = word;
        exec_done  = 1'b1;
        next_sel   = sel;
        branch_tgt = tgt;
        jalr_tgt   = tgt;
        #1;
        chk({tag, ".req"},  32'(imem_req), 32'd1);
        chk({tag, ".addr"}, imem_addr,     pc);
        step();
        chk({tag, ".ivld"},  32'(instr_valid), 32'd1);
        chk({tag, ".instr"}, instr,            word);
        step();
        chk({tag, ".pc_ld"},   32'(pc_ld),      32'd1);
        chk({tag, ".pc_data"}, pc_data,         exp_pc);
        chk({tag, ".mis"},     32'(misaligned), 32'(exp_mis));
        chk({tag, ".instret"}, instret,         exp_ret);
        step();
        chk({tag, ".pc_ld_off"}, 32'(pc_ld), 32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        pc_count   = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        next_sel   = 2'd0;
        branch_tgt = 32'h0;
        jalr_tgt   = 32'h0;
        trap_vec   = 32'h0000_0100;
        imem_rdata = 32'h0;

        step();
        step();
        chk_all_zero("reset");

        // First instruction straight out of reset: pc_ld in cycle 3
        rstn       = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        exec_done  = 1'b1;
        step();
        chk("c1.req",   32'(imem_req),    32'd1);
        chk("c1.addr",  imem_addr,        32'h0);
        chk("c1.pc_ld", 32'(pc_ld),       32'd0);
        step();
        chk("c2.ivld",  32'(instr_valid), 32'd1);
        chk("c2.req",   32'(imem_req),    32'd0);
        chk("c2.instr", instr,            32'h0050_0093);
        chk("c2.pc_ld", 32'(pc_ld),       32'd0);
        step();
        chk("c3.pc_ld",   32'(pc_ld), 32'd1);
        chk("c3.pc_data", pc_data,    32'h0000_0004);
        chk("c3.instret", instret,    32'd1);
        step();
        chk("c4.pc_ld", 32'(pc_ld),    32'd0);
        chk("c4.req",   32'(imem_req), 32'd1);

        // Delayed ack: request held for 6 cycles, exec_done ignored in FETCH
        pc_count   = 32'h0000_0040;
        imem_ack   = 1'b0;
        exec_done  = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wait.req",   32'(imem_req),    32'd1);
            chk("wait.addr",  imem_addr,        32'h0000_0040);
            chk("wait.ivld",  32'(instr_valid), 32'd0);
            chk("wait.pc_ld", 32'(pc_ld),       32'd0);
            step();
        end
        imem_ack  = 1'b1;
        exec_done = 1'b0;
        #1;
        chk("ack.req", 32'(imem_req), 32'd1);
        step();
        chk("ack.instr", instr, 32'hDEAD_BEEF);
        // Spurious ack in EXEC must not recapture
        imem_rdata = 32'h1234_5678;
        next_sel   = 2'd1;
        branch_tgt = 32'h0000_0200;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("exwait.ivld",  32'(instr_valid), 32'd1);
            chk("exwait.instr", instr,            32'hDEAD_BEEF);
            chk("exwait.pc_ld", 32'(pc_ld),       32'd0);
        end
        exec_done = 1'b1;
        step();
        chk("br.pc_ld",   32'(pc_ld), 32'd1);
        chk("br.pc_data", pc_data,    32'h0000_0200);
        chk("br.instret", instret,    32'd2);
        step();

        one_instr("wrap", 32'hFFFF_FFFC, 2'd0, 32'h0, 32'h0000_0000, 1'b0, 32'd3);
`ifdef MISALIGN_TRAP_EN
        one_instr("jalr", 32'h0000_0010, 2'd2, 32'h0000_1003, 32'h0000_0100, 1'b1, 32'd4);
`else
        one_instr("jalr", 32'h0000_0010, 2'd2, 32'h0000_1003, 32'h0000_1000, 1'b0, 32'd4);
`endif
        one_instr("trap", 32'h0000_0020, 2'd3, 32'h0000_0444, 32'h0000_0100, 1'b0, 32'd5);
        one_instr("jalr_al", 32'h0000_0030, 2'd2, 32'h0000_2005, 32'h0000_2004, 1'b0, 32'd6);

        // Reset during EXEC abandons the instruction
        rstn      = 1'b0;
        exec_done = 1'b0;
        step();
        rstn     = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        chk("rx.ivld", 32'(instr_valid), 32'd1);
        rstn      = 1'b0;
        exec_done = 1'b1;
        step();
        chk_all_zero("rx");
        step();
        chk("rx2.pc_ld",   32'(pc_ld), 32'd0);
        chk("rx2.instret", instret,    32'd0);

        // After release, exec_done in FETCH without ack causes no transition
        rstn     = 1'b1;
        imem_ack = 1'b0;
        step();
        step();
        chk("sp.req",   32'(imem_req),    32'd1);
        chk("sp.ivld",  32'(instr_valid), 32'd0);
        chk("sp.pc_ld", 32'(pc_ld),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_next_ctrl.md
PC_NEXT_CTRL -- requirements
Module: pc_next_ctrl

Interface
REQ-001 The block SHALL use reset rstn, synchronous, active-low, and clock clk.
REQ-002 Ports SHALL be, one per line, as follows:
  clk  in  1  clock, all state on rising edge
  rstn  in  1  synchronous active-low reset
  pc_count  in  32  current PC from the program counter register
  pc_ld  out  1  load strobe to the program counter
  pc_data  out  32  next PC value to load
  imem_req  out  1  instruction fetch request
  imem_addr  out  32  fetch address
  imem_ack  in  1  fetch data valid this cycle
  imem_rdata  in  32  fetched instruction
  instr  out  32  latched instruction
  instr_valid  out  1  instr valid for execution
  exec_done  in  1  execution of instr finished, next_sel/targets valid
  next_sel  in  2  0=seq, 1=branch/jal, 2=jalr, 3=trap
  branch_tgt  in  32  branch/jal target
  jalr_tgt  in  32  jalr target
  trap_vec  in  32  trap vector
  misaligned  out  1  one-cycle pulse, misaligned target redirected
  instret  out  32  retired instruction count

Function
REQ-003 The FSM SHALL have states FETCH, EXEC, UPDATE; it SHALL leave reset in FETCH.
REQ-004 FETCH: imem_req=1, imem_addr=pc_count; the state SHALL be held until imem_ack=1.
REQ-005 On imem_ack in FETCH, instr SHALL capture imem_rdata, and the state SHALL go to EXEC on the next edge.
REQ-006 EXEC: instr_valid=1, imem_req=0; the state SHALL be held until exec_done=1, at which next_sel and targets SHALL be registered, then the state SHALL go to UPDATE.
REQ-007 UPDATE: pc_ld=1 for exactly one cycle with pc_data set per the registered selection; instret SHALL increment by 1; the state SHALL then go to FETCH.
REQ-008 Selection: seq -> pc_count+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); 1 -> branch_tgt; 2 -> jalr_tgt with bit0 cleared; 3 -> trap_vec.
REQ-009 Minimum instruction period: FETCH(1, ack same cycle) + EXEC(1) + UPDATE(1) = 3 cycles.
REQ-010 imem_ack outside FETCH SHALL be ignored; exec_done outside EXEC SHALL be ignored.
REQ-011 pc_ld SHALL be 0 in every state except UPDATE; instr SHALL remain stable from capture until the next capture.
REQ-012 instret SHALL wrap 0xFFFFFFFF -> 0x00000000.

Reset
REQ-013 While rstn=0 at an edge: state=FETCH, pc_ld=0, pc_data=0, imem_req=0, instr=0, instr_valid=0, misaligned=0, instret=0.
REQ-014 imem_req SHALL first assert in the first cycle after rstn is sampled high.
REQ-015 Reset in any state SHALL abandon the outstanding fetch/execution with no pc_ld and no instret increment.

Configuration
REQ-016 With MISALIGN_TRAP_EN defined, a selected pc_data candidate (sel 1 or 2) with bits[1:0]!=00 SHALL be replaced by trap_vec, with misaligned pulsed in the UPDATE cycle.
REQ-017 Without MISALIGN_TRAP_EN, pc_data bits[1:0] SHALL be forced to 00, and misaligned SHALL be tied to 0.

Structure
REQ-018 Package pc_pkg SHALL hold: next_sel_t enum (SEL_SEQ, SEL_BR, SEL_JALR, SEL_TRAP), fsm state enum, PC_INCR=32'd4, PC_RESET=32'd0.
REQ-019 The combinational selection (REQ-008, REQ-016/017) SHALL be a sub-module pc_next_mux; the FSM and registers SHALL stay in pc_next_ctrl.

Verification
REQ-020 Reset, then release with pc_count=0x0, imem_ack=1 immediately, exec_done=1 in EXEC, next_sel=0 -> pc_ld pulses at cycle 3 with pc_data=0x00000004, instret=1.
REQ-021 imem_ack delayed 5 cycles -> imem_req/imem_addr held stable for 6 cycles, instr_valid stays 0 until ack, no pc_ld.
REQ-022 pc_count=0xFFFFFFFC, next_sel=0 -> pc_data=0x00000000.
REQ-023 next_sel=2, jalr_tgt=0x00001003, trap_vec=0x00000100 -> with MISALIGN_TRAP_EN: pc_data=0x00000100 and misaligned=1; without it: pc_data=0x00001000 and misaligned=0.
REQ-024 rstn dropped during EXEC -> next cycle all outputs 0, instret unchanged at 0 from reset, no pc_ld; spurious imem_ack/exec_done in wrong states produce no transition.
